// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned INST_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef enum logic [0:0] {StRun, StHalt} fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return {pc[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, inst} fetch entries; flush overrides push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the PC, fetches from a combinational ROM into a FIFO.
// Optional FETCH_FAULT_EN stalls with a sticky fault on fetches above LAST_PC.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 8'd4,
  parameter int unsigned       FIFO_DEPTH = 2
`ifdef FETCH_FAULT_EN
  ,
  parameter logic [ADDR_W-1:0] LAST_PC    = 8'd28
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              halted,
  output logic              fetch_fault
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  logic              push, pop, over_range;
  logic              fifo_full, fifo_empty;
  fetch_entry_t      wentry, head;

  assign rom_addr = pc_q;
  assign pop      = inst_valid && inst_ready;
  assign wentry   = '{pc: pc_q, inst: rom_data};

`ifdef FETCH_FAULT_EN
  assign over_range = (pc_q > LAST_PC);
`else
  assign over_range = 1'b0;
`endif

  // Redirect outranks everything; halt_req still lets this cycle's fetch complete.
  always_comb begin
    push    = 1'b0;
    pc_d    = pc_q;
    state_d = state_q;
    fault_d = fault_q;
    if (redirect_valid) begin
      pc_d    = align_pc(redirect_pc);
      state_d = StRun;
      fault_d = 1'b0;
    end else if (state_q == StRun) begin
      if (over_range) begin
        fault_d = 1'b1;
      end else if (!fifo_full || pop) begin
        push = 1'b1;
        pc_d = pc_q + PC_STEP;
      end
      if (halt_req) state_d = StHalt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  fetch_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(redirect_valid),
    .wdata_i(wentry),
    .rdata_o(head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign inst_valid  = !fifo_empty;
  assign inst_out    = fifo_empty ? '0 : head.inst;
  assign inst_pc     = fifo_empty ? '0 : head.pc;
  assign halted      = (state_q == StHalt) && fifo_empty;
  assign fetch_fault = fault_q;

endmodule
